// File: rtl/nou_pwu_pkg.sv
// Shared PWU/NOU response definitions.
// Provides the response field widths, the header-body and error flit
// layouts, the emitter phase encoding and the error counter width.
// Packed structs list fields MSB first, so the last field sits at bit 0.
package nou_pwu_pkg;

    localparam int NOU_SID_WIDTH         = 4;
    localparam int NOU_RSP_TYPE_ID_WIDTH = 3;
    localparam int NOU_PKT_ID_WIDTH      = 12;
    localparam int NOU_ERR_CODE_WIDTH    = 8;
    localparam int NOU_WL_RM_WIDTH       = 16;
    localparam int ERR_CNT_W             = 16;

    // Header flit without the sequence number; seq is prepended above it
    // because its width is a per-instance parameter.
    typedef struct packed {
        logic [NOU_SID_WIDTH-1:0]         sid;
        logic [NOU_RSP_TYPE_ID_WIDTH-1:0] rsp_type;
        logic [NOU_PKT_ID_WIDTH-1:0]      pkt_id;
        logic                             status;
    } hdr_body_t;

    typedef struct packed {
        logic [NOU_ERR_CODE_WIDTH-1:0] err_code;
        logic [NOU_WL_RM_WIDTH-1:0]    rm;
    } err_flit_t;

    localparam int HDR_BODY_W = $bits(hdr_body_t);
    localparam int ERR_FLIT_W = $bits(err_flit_t);

    typedef enum logic {
        PHASE_HDR = 1'b0,
        PHASE_ERR = 1'b1
    } phase_e;

endpackage

// File: rtl/pwu_rsp_oreg.sv
// Valid/ready output register with load/hold.
// Ports: clk, rstn (sync, active-low), i_vld/i_data (candidate entry),
// i_rdy (downstream ready), o_load (register may take a new value this
// cycle), o_vld/o_data (registered output).
// Data is only captured when a valid entry is loaded, so it stays stable
// while the output is stalled.
module pwu_rsp_oreg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         i_vld,
    input  logic [W-1:0] i_data,
    input  logic         i_rdy,
    output logic         o_load,
    output logic         o_vld,
    output logic [W-1:0] o_data
);

    logic         r_vld;
    logic [W-1:0] r_data;

    assign o_load = ~r_vld | i_rdy;
    assign o_vld  = r_vld;
    assign o_data = r_data;

    // Output register: load when empty or accepted, otherwise hold.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_vld  <= 1'b0;
            r_data <= {W{1'b0}};
        end else if (o_load) begin
            r_vld <= i_vld;
            if (i_vld) begin
                r_data <= i_data;
            end
        end
    end

endmodule

// File: rtl/pwu_rsp_emit.sv
// PWU response emitter.
// Serializes each retired entry into a header flit and, for failed
// responses, a following error flit on a valid/ready port.
// Ports: clk, rstn (sync, active-low); in_* retire entry fields;
// retire_keep (hold request to the retire register, combinational);
// rsp_vld/rsp_rdy/rsp_flit/rsp_last response port; err_cnt error count.
// Build option: NOU_PWU_RSP_ERR_CNT_EN enables the saturating error
// response counter; otherwise err_cnt is tied to zero.
module pwu_rsp_emit
    import nou_pwu_pkg::*;
#(
    parameter int FLIT_W = 64,
    parameter int SEQ_W  = 8
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             in_vld,
    input  logic [NOU_SID_WIDTH-1:0]         in_sid,
    input  logic [NOU_RSP_TYPE_ID_WIDTH-1:0] in_rsp_type,
    input  logic [NOU_PKT_ID_WIDTH-1:0]      in_pkt_id,
    input  logic                             in_status,
    input  logic [NOU_ERR_CODE_WIDTH-1:0]    in_err_code,
    input  logic [NOU_WL_RM_WIDTH-1:0]       in_rm,
    output logic                             retire_keep,
    output logic                             rsp_vld,
    input  logic                             rsp_rdy,
    output logic [FLIT_W-1:0]                rsp_flit,
    output logic                             rsp_last,
    output logic [ERR_CNT_W-1:0]             err_cnt
);

    localparam int HDR_W = SEQ_W + HDR_BODY_W;

    if ((FLIT_W < HDR_W) || (FLIT_W < ERR_FLIT_W)) begin : g_flit_w_chk
        $error("pwu_rsp_emit: FLIT_W too small for header or error flit");
    end

    phase_e             r_phase;
    phase_e             w_phase_nxt;
    logic [SEQ_W-1:0]   r_seq;
    logic [SEQ_W-1:0]   w_seq_nxt;
    logic               w_load;
    logic               w_fire;
    hdr_body_t          w_hdr_body;
    err_flit_t          w_err;
    logic [FLIT_W-1:0]  w_hdr_flit;
    logic [FLIT_W-1:0]  w_err_flit;
    logic [FLIT_W:0]    w_oreg_d;
    logic [FLIT_W:0]    w_oreg_q;

    assign w_hdr_body = '{sid: in_sid, rsp_type: in_rsp_type,
                          pkt_id: in_pkt_id, status: in_status};
    assign w_err      = '{err_code: in_err_code, rm: in_rm};
    assign w_hdr_flit = FLIT_W'({r_seq, w_hdr_body});
    assign w_err_flit = FLIT_W'(w_err);
    assign w_fire     = in_vld & w_load;

    // The entry is released only when its last flit is loaded.
    assign retire_keep = in_vld & ~(w_load & ((r_phase == PHASE_ERR) | ~in_status));

    // Next flit selection and phase/sequence update.
    always_comb begin
        w_phase_nxt = r_phase;
        w_seq_nxt   = r_seq;
        w_oreg_d    = {~in_status, w_hdr_flit};
        case (r_phase)
            PHASE_HDR: begin
                w_oreg_d = {~in_status, w_hdr_flit};
                if (w_fire) begin
                    w_seq_nxt   = r_seq + SEQ_W'(1);
                    w_phase_nxt = in_status ? PHASE_ERR : PHASE_HDR;
                end else begin
                    w_seq_nxt   = r_seq;
                    w_phase_nxt = PHASE_HDR;
                end
            end
            PHASE_ERR: begin
                w_oreg_d = {1'b1, w_err_flit};
                if (w_fire) begin
                    w_phase_nxt = PHASE_HDR;
                end else begin
                    w_phase_nxt = PHASE_ERR;
                end
            end
            default: begin
                w_phase_nxt = PHASE_HDR;
            end
        endcase
    end

    // Phase and sequence-number state.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_phase <= PHASE_HDR;
            r_seq   <= {SEQ_W{1'b0}};
        end else begin
            r_phase <= w_phase_nxt;
            r_seq   <= w_seq_nxt;
        end
    end

    pwu_rsp_oreg #(
        .W (FLIT_W + 1)
    ) u_oreg (
        .clk    (clk),
        .rstn   (rstn),
        .i_vld  (in_vld),
        .i_data (w_oreg_d),
        .i_rdy  (rsp_rdy),
        .o_load (w_load),
        .o_vld  (rsp_vld),
        .o_data (w_oreg_q)
    );

    assign rsp_last = w_oreg_q[FLIT_W];
    assign rsp_flit = w_oreg_q[FLIT_W-1:0];

`ifdef NOU_PWU_RSP_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] r_err_cnt;

    // Saturating count of error headers loaded.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_err_cnt <= {ERR_CNT_W{1'b0}};
        end else if (w_fire && (r_phase == PHASE_HDR) && in_status &&
                     (r_err_cnt != {ERR_CNT_W{1'b1}})) begin
            r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
        end else begin
            r_err_cnt <= r_err_cnt;
        end
    end

    assign err_cnt = r_err_cnt;
`else
    assign err_cnt = {ERR_CNT_W{1'b0}};
`endif

endmodule
